// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side burst reader.
package fifo_rd_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int CNT_WIDTH  = 16;
  localparam int RD_LAT     = 1;
  localparam int SKID_DEPTH = 2;
  localparam int OCC_WIDTH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True while buffered plus in-flight words leave room for one more read.
  function automatic logic f_skid_room(input logic [OCC_WIDTH-1:0] occ, input logic inflight);
    logic [OCC_WIDTH:0] sum;
    sum = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight};
    return (int'(sum) < SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_burst_reader_skid.sv
// Two-entry valid/ready buffer; an arriving word cuts straight through when
// the buffer is empty so a ready sink sees it in the same cycle.
module skid_buf2
  import fifo_rd_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [Data_Width-1:0] i_push_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [Data_Width-1:0] o_data,
  output logic [OCC_WIDTH-1:0]  o_occ
);

  logic [Data_Width-1:0] r_d0;
  logic [Data_Width-1:0] r_d1;
  logic [OCC_WIDTH-1:0]  r_occ;
  logic                  w_valid;
  logic                  w_pop;

  // Head selection: stored head first, otherwise the word arriving this cycle.
  always_comb begin
    w_valid = (r_occ != 2'd0) || i_push;
    w_pop   = w_valid && i_ready;
    if ((r_occ == 2'd0) && i_push) begin
      o_data = i_push_data;
    end else begin
      o_data = r_d0;
    end
  end

  // Storage update; a push into a full buffer cannot happen under the issue rule.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d0  <= {Data_Width{1'b0}};
      r_d1  <= {Data_Width{1'b0}};
      r_occ <= 2'd0;
    end else begin
      case (r_occ)
        2'd0: begin
          if (i_push && !i_ready) begin
            r_d0  <= i_push_data;
            r_occ <= 2'd1;
          end
        end
        2'd1: begin
          if (w_pop) begin
            if (i_push) begin
              r_d0 <= i_push_data;
            end else begin
              r_occ <= 2'd0;
            end
          end else if (i_push) begin
            r_d1  <= i_push_data;
            r_occ <= 2'd2;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_d0 <= r_d1;
            if (i_push) begin
              r_d1 <= i_push_data;
            end else begin
              r_occ <= 2'd1;
            end
          end
        end
        default: r_occ <= 2'd0;
      endcase
    end
  end

  assign o_valid = w_valid;
  assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_rd_burst_reader.sv
// Read-domain burst consumer: pulls burst_len words from the FIFO read port
// and forwards them on a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH,
  parameter int Cnt_Width  = CNT_WIDTH,
  parameter int Rd_Lat     = RD_LAT
) (
  input  logic                  i_rd_clk,
  input  logic                  i_rd_rst,
  input  logic                  i_start,
  input  logic [Cnt_Width-1:0]  i_burst_len,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic                  i_empty,
  output logic                  o_rd_en,
  input  logic [Data_Width-1:0] i_data_out,
  output logic [Data_Width-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [Cnt_Width-1:0]  o_xfer_count
);

  localparam logic [Cnt_Width-1:0] CNT_ZERO = {Cnt_Width{1'b0}};
  localparam logic [Cnt_Width-1:0] CNT_ONE  = {{(Cnt_Width-1){1'b0}}, 1'b1};

  state_e                 r_state;
  state_e                 w_next;
  logic [Cnt_Width-1:0]   r_len;
  logic [Cnt_Width-1:0]   r_issued;
  logic [Cnt_Width-1:0]   r_xfer;
  logic [Rd_Lat-1:0]      r_lat_pipe;
  logic                   w_inflight;
  logic                   w_rd_en;
  logic                   w_xfer;
  logic                   w_accept;
  logic [OCC_WIDTH-1:0]   w_occ;
  logic                   w_m_valid;
  logic [Data_Width-1:0]  w_m_data;

  // The occupancy bound counts a single in-flight word, so only Rd_Lat=1 is supported.
  assign w_inflight = r_lat_pipe[Rd_Lat-1];
  assign w_xfer     = w_m_valid && i_m_ready;
  assign w_accept   = (r_state == ST_IDLE) && i_start;

  // FSM state register.
  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_burst_len == CNT_ZERO) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_RUN;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_rd_en && ((r_issued + CNT_ONE) == r_len)) begin
          w_next = ST_DRAIN;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if ((r_xfer == r_len) && (w_occ == 2'd0) && !w_inflight) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_DRAIN;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: read strobe, busy and the done pulse.
  always_comb begin
    w_rd_en = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_rd_en = !i_empty && (r_issued < r_len) && f_skid_room(w_occ, w_inflight);
        o_busy  = 1'b1;
      end
      ST_DRAIN: o_busy = 1'b1;
      ST_DONE:  o_done = 1'b1;
      default: begin
        w_rd_en = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
      end
    endcase
  end

  // Burst length, issue/transfer counters and the read-latency pipe.
  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      r_len      <= CNT_ZERO;
      r_issued   <= CNT_ZERO;
      r_xfer     <= CNT_ZERO;
      r_lat_pipe <= {Rd_Lat{1'b0}};
    end else begin
      if (w_accept) begin
        r_len    <= i_burst_len;
        r_issued <= CNT_ZERO;
        r_xfer   <= CNT_ZERO;
      end else begin
        if (w_rd_en) begin
          r_issued <= r_issued + CNT_ONE;
        end
        if (w_xfer) begin
          r_xfer <= r_xfer + CNT_ONE;
        end
      end
      r_lat_pipe <= Rd_Lat'({r_lat_pipe, w_rd_en});
    end
  end

  skid_buf2 #(
    .Data_Width (Data_Width)
  ) u_skid (
    .i_clk       (i_rd_clk),
    .i_rst       (i_rd_rst),
    .i_push      (w_inflight),
    .i_push_data (i_data_out),
    .i_ready     (i_m_ready),
    .o_valid     (w_m_valid),
    .o_data      (w_m_data),
    .o_occ       (w_occ)
  );

  assign o_rd_en      = w_rd_en;
  assign o_m_valid    = w_m_valid;
  assign o_m_data     = w_m_data;
  assign o_xfer_count = r_xfer;

endmodule

// File: tb/tb_fifo_rd_burst_reader.sv
// Directed bench for fifo_rd_burst_reader: per-cycle vector table plus
// hand-written burst sequences against a simple FIFO model.
module tb_fifo_rd_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] burst_len = 16'd0;
  logic        busy, done, empty, rd_en, m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  data_out = 8'd0;
  logic [7:0]  m_data;
  logic [15:0] xfer_count;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_rd_burst_reader dut (
    .i_rd_clk     (clk),
    .i_rd_rst     (rst),
    .i_start      (start),
    .i_burst_len  (burst_len),
    .o_busy       (busy),
    .o_done       (done),
    .i_empty      (empty),
    .o_rd_en      (rd_en),
    .i_data_out   (data_out),
    .o_m_data     (m_data),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_xfer_count (xfer_count)
  );

  // FIFO model with 1-cycle read latency.
  logic [7:0] fmem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      data_out <= fmem[rd_ptr % 64];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] d);
    fmem[wr_ptr % 64] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic        ready;
    logic        e_rd_en;
    logic        e_valid;
    logic        e_cd;
    logic [7:0]  e_data;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_xfer;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic [15:0] l, input logic rdy,
                              input logic erd, input logic ev, input logic ecd, input logic [7:0] ed,
                              input logic eb, input logic edn, input logic [15:0] ex);
    vec_t v;
    v.rst = r; v.start = s; v.len = l; v.ready = rdy;
    v.e_rd_en = erd; v.e_valid = ev; v.e_cd = ecd; v.e_data = ed;
    v.e_busy = eb; v.e_done = edn; v.e_xfer = ex;
    return v;
  endfunction

  // One burst with a periodic ready pattern and an optional late refill of the FIFO.
  task automatic run_burst(input string tag, input logic [15:0] len, input logic [7:0] base,
                           input int ready_period, input int late_at, input int late_n,
                           input logic [7:0] late_base);
    int got = 0;
    int n_done = 0;
    int cyc = 0;
    int occ_sum;
    logic stall = 1'b0;
    logic [7:0] held = 8'd0;
    @(negedge clk);
    start = 1'b1; burst_len = len; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n_done == 0 && cyc < 200) begin
      m_ready = ((cyc % ready_period) == 0);
      #1;
      chk({tag, "_rd_en_while_empty"}, 32'(rd_en & empty), 32'd0);
      occ_sum = int'(dut.w_occ) + int'(dut.w_inflight);
      chk({tag, "_occ_bound"}, 32'(occ_sum <= 2), 32'd1);
      if (stall) begin
        chk({tag, "_stall_valid"}, 32'(m_valid), 32'd1);
        chk({tag, "_stall_data"}, 32'(m_data), 32'(held));
      end
      if (m_valid && m_ready) begin
        chk($sformatf("%s_data%0d", tag, got), 32'(m_data), 32'(base + 8'(got)));
        got++;
      end
      stall = m_valid && !m_ready;
      held  = m_data;
      if (empty && got < int'(len)) chk({tag, "_busy_starved"}, 32'(busy), 32'd1);
      if (done) n_done++;
      if (cyc == late_at) begin
        for (int i = 0; i < late_n; i++) push(late_base + 8'(i));
      end
      cyc++;
      @(negedge clk);
    end
    #1;
    chk({tag, "_done_seen"}, 32'(n_done), 32'd1);
    chk({tag, "_delivered"}, 32'(got), 32'(len));
    chk({tag, "_xfer_count"}, 32'(xfer_count), 32'(len));
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs [18];
  int   got_r;

  initial begin
    // Reset, idle with data available, then an 8-word burst at full rate.
    vecs[0]  = mk(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[1]  = mk(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[2]  = mk(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[3]  = mk(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[4]  = mk(1'b0, 1'b1, 16'd8, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0);
    vecs[5]  = mk(1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0);
    for (int k = 0; k < 7; k++) begin
      vecs[6 + k] = mk(1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10 + 8'(k), 1'b1, 1'b0, 16'(k));
    end
    vecs[13] = mk(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h17, 1'b1, 1'b0, 16'd7);
    vecs[14] = mk(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd8);
    // start arriving together with done must be ignored.
    vecs[15] = mk(1'b0, 1'b1, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd8);
    vecs[16] = mk(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd8);
    vecs[17] = mk(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd8);

    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    @(posedge clk);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; start = vecs[i].start; burst_len = vecs[i].len; m_ready = vecs[i].ready;
      #1;
      chk($sformatf("v%0d_rd_en", i), 32'(rd_en), 32'(vecs[i].e_rd_en));
      chk($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_cd) chk($sformatf("v%0d_m_data", i), 32'(m_data), 32'(vecs[i].e_data));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      chk($sformatf("v%0d_xfer", i), 32'(xfer_count), 32'(vecs[i].e_xfer));
    end

    // Back-pressure: ready pattern 1,0,0 repeating.
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    run_burst("stall", 16'd8, 8'h40, 3, -1, 0, 8'h00);

    // Starvation: 3 words, FIFO empty for ~10 cycles, then 2 more.
    for (int i = 0; i < 3; i++) push(8'h20 + 8'(i));
    run_burst("starve", 16'd5, 8'h20, 1, 12, 2, 8'h23);

    // Zero-length burst with data sitting in the FIFO.
    @(negedge clk);
    push(8'h30); push(8'h31);
    start = 1'b1; burst_len = 16'd0;
    #1;
    chk("zero_done_c1", 32'(done), 32'd0);
    chk("zero_rd_en_c1", 32'(rd_en), 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zero_done_c2", 32'(done), 32'd1);
    chk("zero_rd_en_c2", 32'(rd_en), 32'd0);
    chk("zero_busy_c2", 32'(busy), 32'd0);
    chk("zero_xfer_c2", 32'(xfer_count), 32'd0);
    @(negedge clk);
    #1;
    chk("zero_done_c3", 32'(done), 32'd0);
    chk("zero_rd_en_c3", 32'(rd_en), 32'd0);
    chk("zero_xfer_c3", 32'(xfer_count), 32'd0);

    // Reset after the second transfer of an 8-word burst.
    for (int i = 2; i < 8; i++) push(8'h30 + 8'(i));
    @(negedge clk);
    start = 1'b1; burst_len = 16'd8; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_r = 0;
    for (int c = 0; c < 30 && got_r < 2; c++) begin
      #1;
      if (m_valid && m_ready) got_r++;
      if (got_r < 2) @(negedge clk);
    end
    chk("rst_two_transfers", 32'(got_r), 32'd2);
    @(negedge clk);
    #1;
    chk("rst_xfer_before", 32'(xfer_count), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_xfer", 32'(xfer_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_no_done", 32'(done), 32'd0);
    chk("rst_still_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
